udp_02467_sweep_ctrl: RTL

Sequencing controller for the UDP_02467 datapath (e = c' + a·b over inputs a, b, c; f = e·d). It either evaluates one operand vector on request, or sweeps all 16 {a,b,c,d} combinations. During a sweep it builds the full minterm map of f and counts the ones in e and f. It sits between a test or configuration master (start/mode handshake) and the combinational evaluation function, which it instantiates.

---
 rtl/udp_02467_pkg.sv | 26 ++
 rtl/udp_02467_sweep_ctrl_fn.sv | 15 +
 rtl/udp_02467_sweep_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/udp_02467_pkg.sv
// Shared types and constants for the UDP_02467 sweep controller.
// The evaluation function has four 1-bit inputs, so a sweep visits 16 points;
// the index and count widths follow from that.
package udp_02467_pkg;

    // Number of {a,b,c,d} combinations visited by a full sweep.
    localparam int SWEEP_LEN = 16;

    // Width of the sweep index (0..15).
    localparam int IDX_W = 4;

    // Width of the ones counters; 5 bits so that a full count of 16 fits.
    localparam int CNT_W = 5;

    // Last index of a sweep; the controller leaves SWEEP after evaluating it.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SWEEP_LEN - 1);

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : udp_02467_pkg

// File: rtl/udp_02467_sweep_ctrl_fn.sv
// Combinational UDP_02467 evaluation function: e = c' + a.b, f = e.d.
module udp_02467_fn (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e,
    output logic f
);

    // Pure two-level logic; the controller registers everything it uses.
    assign e = ~c | (a & b);
    assign f = e & d;

endmodule : udp_02467_fn

// File: rtl/udp_02467_sweep_ctrl.sv
// Sequencing controller for the UDP_02467 datapath.
// Either evaluates one captured operand (single mode) or walks all 16
// {a,b,c,d} combinations (sweep mode), building the minterm map of f and
// counting the ones in e and f. A single function instance is shared between
// the two modes through an operand mux. Every output comes from a register.
module udp_02467_sweep_ctrl
    import udp_02467_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [3:0]        abcd_in,
    output logic              busy,
    output logic              done,
    output logic              e_out,
    output logic              f_out,
    output logic [15:0]       minterm_map,
    output logic [CNT_W-1:0]  e_count,
    output logic [CNT_W-1:0]  f_count
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              state_reg;
    state_t              state_next;

    logic [3:0]          op_reg;
    logic [3:0]          op_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_next;
    logic                e_out_reg;
    logic                e_out_next;
    logic                f_out_reg;
    logic                f_out_next;
    logic [15:0]         map_reg;
    logic [15:0]         map_next;
    logic [CNT_W-1:0]    e_cnt_reg;
    logic [CNT_W-1:0]    e_cnt_next;
    logic [CNT_W-1:0]    f_cnt_reg;
    logic [CNT_W-1:0]    f_cnt_next;
    logic                busy_reg;
    logic                busy_next;
    logic                done_reg;
    logic                done_next;

    // Decoded control
    logic                accept_single;
    logic                accept_sweep;
    logic                sweeping;
    logic [3:0]          fn_operand;
    logic                fn_e;
    logic                fn_f;
    logic [SWEEP_LEN-1:0] map_hit;

    assign accept_single = (state_reg == IDLE) && start && !mode;
    assign accept_sweep  = (state_reg == IDLE) && start &&  mode;
    assign sweeping      = (state_reg == SWEEP);

    // Shared evaluation: sweep index while sweeping, captured operand otherwise.
    assign fn_operand = sweeping ? idx_reg : op_reg;

    udp_02467_fn u_fn (
        .a (fn_operand[3]),
        .b (fn_operand[2]),
        .c (fn_operand[1]),
        .d (fn_operand[0]),
        .e (fn_e),
        .f (fn_f)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register; reset returns to IDLE immediately, dropping any sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE, DONE always falls back.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = mode ? SWEEP : EVAL;
                end
            end
            EVAL: begin
                state_next = DONE;
            end
            SWEEP: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------

    // One-hot write enable into the minterm map, one bit per sweep index.
    generate
        for (genvar gi = 0; gi < SWEEP_LEN; gi++) begin : g_map
            localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
            assign map_hit[gi]  = sweeping && (idx_reg == GI_IDX);
            assign map_next[gi] = accept_sweep ? 1'b0
                                : map_hit[gi]  ? fn_f
                                :                map_reg[gi];
        end
    endgenerate

    // Operand capture, index stepping, single results, counters and flags.
    always_comb begin
        op_next    = op_reg;
        idx_next   = idx_reg;
        e_out_next = e_out_reg;
        f_out_next = f_out_reg;
        e_cnt_next = e_cnt_reg;
        f_cnt_next = f_cnt_reg;

        if (accept_single) begin
            op_next = abcd_in;
        end

        if (accept_sweep) begin
            idx_next   = '0;
            e_cnt_next = '0;
            f_cnt_next = '0;
        end else if (sweeping) begin
            // Index wraps to 0 naturally after the last point.
            idx_next   = idx_reg + 1'b1;
            e_cnt_next = e_cnt_reg + CNT_W'(fn_e);
            f_cnt_next = f_cnt_reg + CNT_W'(fn_f);
        end

        if (state_reg == EVAL) begin
            e_out_next = fn_e;
            f_out_next = fn_f;
        end

        // Flags are registered from the next state so they line up with it.
        busy_next = (state_next == EVAL) || (state_next == SWEEP);
        done_next = (state_next == DONE);
    end

    // Datapath registers; all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg    <= '0;
            idx_reg   <= '0;
            e_out_reg <= 1'b0;
            f_out_reg <= 1'b0;
            map_reg   <= '0;
            e_cnt_reg <= '0;
            f_cnt_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            op_reg    <= op_next;
            idx_reg   <= idx_next;
            e_out_reg <= e_out_next;
            f_out_reg <= f_out_next;
            map_reg   <= map_next;
            e_cnt_reg <= e_cnt_next;
            f_cnt_reg <= f_cnt_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign e_out       = e_out_reg;
    assign f_out       = f_out_reg;
    assign minterm_map = map_reg;
    assign e_count     = e_cnt_reg;
    assign f_count     = f_cnt_reg;

endmodule : udp_02467_sweep_ctrl
